cache_tag_lookup: RTL and testbench
===================================

# cache_tag_lookup

Lookup and replacement controller that sits directly downstream of the cache tag array. It consumes the eight stored tags (two sets of four ways, entries 0-3 = set 0, entries 4-7 = set 1), compares them against a requested tag, and reports hit/way. On a miss it picks a victim (first invalid way, else tree pseudo-LRU) and drives the array's one-hot write enable and write tag to fill it. It owns the per-entry valid bits and the PLRU state, which the tag array does not hold.

## Interface
- Parameters: none (tag width fixed at 24, 2 sets x 4 ways).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_set  in  1  set index (0: entries 0-3, 1: entries 4-7)
- req_tag  in  24  tag to look up
- flush  in  1  clear all valid bits and PLRU state; sampled only when req_ready=1
- resp_valid  out  1  response valid, held until resp_ready
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_hit  out  1  1 = hit, 0 = miss (line filled)
- resp_way  out  2  way hit or way filled, within the set
- resp_evict  out  1  miss replaced a valid entry
- resp_evict_tag  out  24  tag of the evicted entry (0 when resp_evict=0)
- we  out  8  one-hot write enable to tag array entries
- tag  out  24  write tag to tag array
- tagOut0..tagOut7  in  24 each  stored tags, valid combinationally at all times

## Operation
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE: req_ready=1. flush=1 takes priority over req_valid: clear valid[7:0] and both PLRU trees, stay IDLE, request not accepted that cycle. Otherwise, on req_valid, latch req_set/req_tag -> LOOKUP.
- LOOKUP: compare latched tag against the four entries of the latched set, only where valid=1. Hit: resp_hit=1, resp_way=matching way (lowest index if several), update PLRU -> RESP. Miss: choose victim, capture resp_evict/resp_evict_tag from victim's valid/tagOut -> FILL.
- Victim: lowest-index invalid way in set; if all valid, PLRU victim.
- PLRU per set, bits b0,b1,b2: b0=0 -> ways 0/1, else ways 2/3; b1=0 -> way0 else way1; b2=0 -> way2 else way3. Access update: way0 -> b0=1,b1=1; way1 -> b0=1,b1=0; way2 -> b0=0,b2=1; way3 -> b0=0,b2=0. The update applies on hit and on fill.
- FILL: we one-hot at entry set*4+way for exactly one cycle, tag=latched tag; set valid bit; PLRU update -> RESP.
- RESP: resp_valid=1, outputs stable until resp_ready; on handshake -> IDLE.
- we=0 in every state except FILL. tag output = latched tag at all times.

## Timing
- Reset (async, reset=0): state IDLE, valid=0, PLRU=0, we=0, tag=0, resp_valid=0, resp_hit=0, resp_way=0, resp_evict=0, resp_evict_tag=0, req_ready=1 after release.
- Request accepted at edge N. Hit: resp_valid from N+2. Miss: we pulse during cycle N+2, resp_valid from N+3.
- Next request acceptable the cycle after the resp handshake (one request in flight; no pipelining).
- resp_ready held high in RESP: resp_valid is 1 for exactly one cycle.
- Reset asserted mid-operation: immediate return to reset values; an in-progress FILL is abandoned and we drops to 0 asynchronously.
- flush and req_valid in the same IDLE cycle: flush wins, request is retried by the source next cycle.

## Test plan
- After reset, request set0 tag 0x00ABCD -> miss, we=8'h01, resp_way=0, resp_evict=0 at N+3; repeat the same request -> hit, way 0 at N+2.
- Fill set1 with tags 0x10,0x11,0x12,0x13 -> we=8'h10,8'h20,8'h40,8'h80 in order; set 0 entries untouched.
- Set1 full (ways 0-3 filled in order, PLRU=b0=0,b2=0) then access way1, request tag 0x14 -> victim way2, resp_evict=1, resp_evict_tag=0x12.
- Hold resp_ready=0 for 5 cycles -> resp_valid and fields stable, req_ready=0 throughout.
- Flush while set0 holds 0x00ABCD, then request it -> miss, victim way 0, resp_evict=0.
- Assert reset during FILL -> we=0 immediately, all outputs at reset values; the following lookup of that tag misses.

Source files
------------

// File: rtl/cache_tag_lookup.sv
// Lookup/replacement controller for a 2-set x 4-way tag array: hit detection,
// victim selection (first invalid, else tree PLRU) and single-cycle fill.
module cache_tag_lookup (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_set,
    input  logic [23:0] req_tag,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_hit,
    output logic [1:0]  resp_way,
    output logic        resp_evict,
    output logic [23:0] resp_evict_tag,
    output logic [7:0]  we,
    output logic [23:0] tag,
    input  logic [23:0] tagOut0,
    input  logic [23:0] tagOut1,
    input  logic [23:0] tagOut2,
    input  logic [23:0] tagOut3,
    input  logic [23:0] tagOut4,
    input  logic [23:0] tagOut5,
    input  logic [23:0] tagOut6,
    input  logic [23:0] tagOut7
);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_valid;
    logic [1:0][2:0] r_plru;
    logic            r_set;
    logic [23:0]     r_tag;
    logic            r_hit;
    logic [1:0]      r_way;
    logic            r_evict;
    logic [23:0]     r_evict_tag;

    logic [23:0]     w_entry [8];
    logic [3:0]      w_set_valid;
    logic [2:0]      w_cur_plru;
    logic            w_hit;
    logic [1:0]      w_hit_way;
    logic            w_has_inv;
    logic [1:0]      w_inv_way;
    logic [1:0]      w_plru_way;
    logic [1:0]      w_victim;

    // Bit 0 of the vector is b0 (pair select), bit 1 is b1, bit 2 is b2.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] way);
        case (way)
            2'd0:    plru_touch = {b[2], 1'b1, 1'b1};
            2'd1:    plru_touch = {b[2], 1'b0, 1'b1};
            2'd2:    plru_touch = {1'b1, b[1], 1'b0};
            default: plru_touch = {1'b0, b[1], 1'b0};
        endcase
    endfunction

    assign w_entry[0] = tagOut0;
    assign w_entry[1] = tagOut1;
    assign w_entry[2] = tagOut2;
    assign w_entry[3] = tagOut3;
    assign w_entry[4] = tagOut4;
    assign w_entry[5] = tagOut5;
    assign w_entry[6] = tagOut6;
    assign w_entry[7] = tagOut7;

    assign w_set_valid = r_set ? r_valid[7:4] : r_valid[3:0];
    assign w_cur_plru  = r_plru[r_set];
    assign w_plru_way  = w_cur_plru[0] ? (w_cur_plru[2] ? 2'd3 : 2'd2)
                                       : (w_cur_plru[1] ? 2'd1 : 2'd0);
    assign w_victim    = w_has_inv ? w_inv_way : w_plru_way;

    // Descending scans so the lowest matching / invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 2'd0;
        w_has_inv = 1'b0;
        w_inv_way = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_set_valid[i] && (w_entry[{r_set, 2'(i)}] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(i);
            end
            if (!w_set_valid[i]) begin
                w_has_inv = 1'b1;
                w_inv_way = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // we is decoded from state so it falls the instant reset forces IDLE.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        we         = 8'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (!flush && req_valid) w_next = LOOKUP;
            end
            LOOKUP: w_next = w_hit ? RESP : FILL;
            FILL: begin
                we     = 8'd1 << {r_set, r_way};
                w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 8'd0;
            r_plru      <= '0;
            r_set       <= 1'b0;
            r_tag       <= 24'd0;
            r_hit       <= 1'b0;
            r_way       <= 2'd0;
            r_evict     <= 1'b0;
            r_evict_tag <= 24'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid <= 8'd0;
                        r_plru  <= '0;
                    end else if (req_valid) begin
                        r_set <= req_set;
                        r_tag <= req_tag;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_hit          <= 1'b1;
                        r_way          <= w_hit_way;
                        r_evict        <= 1'b0;
                        r_evict_tag    <= 24'd0;
                        r_plru[r_set]  <= plru_touch(w_cur_plru, w_hit_way);
                    end else begin
                        r_hit       <= 1'b0;
                        r_way       <= w_victim;
                        r_evict     <= w_set_valid[w_victim];
                        r_evict_tag <= w_set_valid[w_victim] ? w_entry[{r_set, w_victim}] : 24'd0;
                    end
                end
                FILL: begin
                    r_valid[{r_set, r_way}] <= 1'b1;
                    r_plru[r_set]           <= plru_touch(w_cur_plru, r_way);
                end
                default: ;
            endcase
        end
    end

    assign tag            = r_tag;
    assign resp_hit       = r_hit;
    assign resp_way       = r_way;
    assign resp_evict     = r_evict;
    assign resp_evict_tag = r_evict_tag;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Bench for cache_tag_lookup: models the tag array, keeps a behavioural cache
// model, and checks every cycle plus directed literal scenarios.
module tb_cache_tag_lookup;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_set = 1'b0;
    logic [23:0] req_tag = 24'd0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        resp_evict;
    logic [23:0] resp_evict_tag;
    logic [7:0]  we;
    logic [23:0] tag;

    // Tag array contents before any fill; entry 0 deliberately holds the first
    // looked-up tag so that an invalid entry must not produce a hit.
    logic [23:0] tarr [8] = '{24'h00ABCD, 24'h5A5A5A, 24'h123456, 24'h0F0F0F,
                              24'h000010, 24'h000011, 24'h000077, 24'hABCDEF};

    int          n_chk = 0;
    int          n_fail = 0;

    bit          mvalid [8];
    logic [23:0] mtag [8];
    logic [2:0]  mplru [2];

    bit          chk_en = 1'b0;
    bit          in_txn = 1'b0;
    bit          exp_hit;
    logic [1:0]  exp_way;
    bit          exp_ev;
    logic [23:0] exp_evt;
    logic [7:0]  exp_we;
    logic [23:0] last_tag = 24'd0;
    int          cyc = 0;
    logic [7:0]  seen_we = 8'd0;
    bit          rv;

    logic        h;
    logic [1:0]  w;
    logic        ev;
    logic [23:0] evt;

    always #5 clk = ~clk;

    cache_tag_lookup dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .we(we), .tag(tag),
        .tagOut0(tarr[0]), .tagOut1(tarr[1]), .tagOut2(tarr[2]), .tagOut3(tarr[3]),
        .tagOut4(tarr[4]), .tagOut5(tarr[5]), .tagOut6(tarr[6]), .tagOut7(tarr[7])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (we[i]) tarr[i] <= tag;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // PLRU as three named bits b0,b1,b2 packed in [0],[1],[2].
    function automatic logic [2:0] touch(input logic [2:0] b, input int way);
        logic [2:0] r;
        r = b;
        case (way)
            0: begin r[0] = 1'b1; r[1] = 1'b1; end
            1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2: begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        mplru[0] = 3'd0;
        mplru[1] = 3'd0;
    endtask

    task automatic predict(input logic s, input logic [23:0] t);
        int base;
        int vic;
        logic [2:0] b;
        base    = s ? 4 : 0;
        exp_hit = 1'b0;
        exp_way = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!exp_hit && mvalid[base + i] && mtag[base + i] == t) begin
                exp_hit = 1'b1;
                exp_way = 2'(i);
            end
        end
        exp_ev  = 1'b0;
        exp_evt = 24'd0;
        exp_we  = 8'd0;
        if (!exp_hit) begin
            vic = -1;
            for (int i = 0; i < 4; i++) if (vic < 0 && !mvalid[base + i]) vic = i;
            if (vic < 0) begin
                b   = mplru[s];
                vic = (b[0] == 1'b0) ? (b[1] ? 1 : 0) : (b[2] ? 3 : 2);
            end
            exp_way = 2'(vic);
            exp_ev  = mvalid[base + vic];
            exp_evt = exp_ev ? mtag[base + vic] : 24'd0;
            exp_we  = 8'd1 << (base + vic);
        end
    endtask

    task automatic model_commit(input logic s, input logic [23:0] t);
        int idx;
        idx = (s ? 4 : 0) + int'(exp_way);
        if (!exp_hit) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = t;
        end
        mplru[s] = touch(mplru[s], int'(exp_way));
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the handshake.
    task automatic do_req(input logic s, input logic [23:0] t, input int hold,
                          output logic oh, output logic [1:0] ow,
                          output logic oev, output logic [23:0] oevt);
        predict(s, t);
        req_valid = 1'b1;
        req_set   = s;
        req_tag   = t;
        @(posedge clk); #1;
        req_valid = 1'b0;
        last_tag  = t;
        in_txn    = 1'b1;
        for (int i = 0; i < 8 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        if (!resp_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL resp_timeout: resp_valid=0 required 1 at %0t", $time);
        end
        oh   = resp_hit;
        ow   = resp_way;
        oev  = resp_evict;
        oevt = resp_evict_tag;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        in_txn     = 1'b0;
        model_commit(s, t);
    endtask

    task automatic do_flush();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_set   = 1'($urandom_range(1));
        req_tag   = 24'h100 + 24'($urandom_range(5));
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_we"}, 32'(we), 32'h0);
        chk({pfx, "_tag"}, 32'(tag), 32'h0);
        chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({pfx, "_resp_hit"}, 32'(resp_hit), 32'h0);
        chk({pfx, "_resp_way"}, 32'(resp_way), 32'h0);
        chk({pfx, "_resp_evict"}, 32'(resp_evict), 32'h0);
        chk({pfx, "_resp_evict_tag"}, 32'(resp_evict_tag), 32'h0);
    endtask

    // Per-cycle comparison against the model's expectation for the current transaction.
    always @(negedge clk) begin
        if (chk_en) begin
            if (we != 8'd0) seen_we = we;
            chk("tag_out", 32'(tag), 32'(last_tag));
            if (!in_txn) begin
                cyc     = 0;
                seen_we = (we != 8'd0) ? we : 8'd0;
                chk("idle_req_ready", 32'(req_ready), 32'h1);
                chk("idle_resp_valid", 32'(resp_valid), 32'h0);
                chk("idle_we", 32'(we), 32'h0);
            end else begin
                cyc++;
                chk("busy_req_ready", 32'(req_ready), 32'h0);
                chk("we", 32'(we), (!exp_hit && cyc == 2) ? 32'(exp_we) : 32'h0);
                rv = (cyc >= (exp_hit ? 2 : 3));
                chk("resp_valid", 32'(resp_valid), 32'(rv));
                if (rv) begin
                    chk("resp_hit", 32'(resp_hit), 32'(exp_hit));
                    chk("resp_way", 32'(resp_way), 32'(exp_way));
                    chk("resp_evict", 32'(resp_evict), 32'(exp_ev));
                    chk("resp_evict_tag", 32'(resp_evict_tag), 32'(exp_evt));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        for (int i = 0; i < 8; i++) mtag[i] = 24'd0;
        #2 reset = 1'b0;
        #1 chk_reset_vals("reset");
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        do_req(1'b0, 24'h00ABCD, 0, h, w, ev, evt);
        chk("first_hit", 32'(h), 32'h0);
        chk("first_we", 32'(seen_we), 32'h01);
        chk("first_way", 32'(w), 32'h0);
        chk("first_evict", 32'(ev), 32'h0);
        do_req(1'b0, 24'h00ABCD, 0, h, w, ev, evt);
        chk("repeat_hit", 32'(h), 32'h1);
        chk("repeat_way", 32'(w), 32'h0);

        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 24'h10 + 24'(i), 0, h, w, ev, evt);
            chk("set1_fill_we", 32'(seen_we), 32'h10 << i);
            chk("set1_fill_way", 32'(w), 32'(i));
        end
        chk("set0_entry0", 32'(tarr[0]), 32'h00ABCD);
        chk("set0_entry1", 32'(tarr[1]), 32'h5A5A5A);
        chk("set0_entry3", 32'(tarr[3]), 32'h0F0F0F);

        do_req(1'b1, 24'h11, 0, h, w, ev, evt);
        chk("way1_hit", 32'(h), 32'h1);
        chk("way1_way", 32'(w), 32'h1);
        do_req(1'b1, 24'h14, 0, h, w, ev, evt);
        chk("plru_way", 32'(w), 32'h2);
        chk("plru_evict", 32'(ev), 32'h1);
        chk("plru_evict_tag", 32'(evt), 32'h12);
        chk("plru_we", 32'(seen_we), 32'h40);

        do_req(1'b0, 24'h00ABCD, 5, h, w, ev, evt);
        chk("hold_hit", 32'(h), 32'h1);

        do_flush();
        do_req(1'b0, 24'h00ABCD, 0, h, w, ev, evt);
        chk("flush_hit", 32'(h), 32'h0);
        chk("flush_way", 32'(w), 32'h0);
        chk("flush_evict", 32'(ev), 32'h0);

        // Reset while a fill of set 1 way 0 is in progress.
        do_flush();
        predict(1'b1, 24'h77);
        req_valid = 1'b1;
        req_set   = 1'b1;
        req_tag   = 24'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        last_tag  = 24'h77;
        in_txn    = 1'b1;
        @(posedge clk); #1;
        chk("fill_we_before_reset", 32'(we), 32'h10);
        #2 reset = 1'b0;
        #1;
        in_txn   = 1'b0;
        last_tag = 24'd0;
        chk_reset_vals("midfill");
        model_clear();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 24'h77, 0, h, w, ev, evt);
        chk("after_reset_hit", 32'(h), 32'h0);
        chk("after_reset_we", 32'(seen_we), 32'h10);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(15) == 0) begin
                do_flush();
            end else begin
                do_req(1'($urandom_range(1)), 24'h100 + 24'($urandom_range(5)),
                       int'($urandom_range(2)), h, w, ev, evt);
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
